// File: rtl/cond_branch_unit.sv
// Decode-stage branch resolver: holds NZCV, evaluates the condition field,
// computes B/BL targets, redirects fetch and requests the BL link write.
module cond_branch_unit #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_b_instr,
  input  logic              id_bl_instr,
  input  logic [3:0]        id_cond,
  input  logic [23:0]       id_imm24,
  input  logic [PC_W-1:0]   id_next_pc,
  input  logic              id_stall,
  input  logic              ex_s_en,
  input  logic [3:0]        ex_flags,
  output logic [3:0]        flags,
  output logic              cond_pass,
  output logic              branch_taken,
  output logic [PC_W-1:0]   branch_target,
  output logic              link_we,
  output logic [PC_W-1:0]   link_value,
  output logic [CNT_W-1:0]  br_count
);

  localparam int unsigned OFF_W = 26;
  localparam int unsigned EXT_W = PC_W - OFF_W;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]      eff_flags;
  logic            fn, fz, fc, fv;
  logic [PC_W-1:0] offset;
  logic            link_req;

  // Same-cycle bypass of the flags EX is writing right now
  assign eff_flags = ex_s_en ? ex_flags : flags;
  assign fn = eff_flags[3];
  assign fz = eff_flags[2];
  assign fc = eff_flags[1];
  assign fv = eff_flags[0];

  // Condition-field evaluation; 0xF is reserved and never executes
  always_comb begin
    cond_pass = 1'b0;
    case (id_cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Word offset sign-extended to PC width; modular add wraps silently
  assign offset        = {{EXT_W{id_imm24[23]}}, id_imm24, 2'b00};
  assign branch_target = id_next_pc + offset;

  // Next state and redirect; the shadow cycle holds the flushed fetch
  always_comb begin
    state_next   = state;
    branch_taken = 1'b0;
    case (state)
      RUN: begin
        if (id_valid && !id_stall && (id_b_instr || id_bl_instr) && cond_pass) begin
          branch_taken = 1'b1;
          state_next   = SHADOW;
        end
      end
      SHADOW: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign link_req = branch_taken && id_bl_instr;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Flag register, written from EX regardless of ID stalls
  always_ff @(posedge clk) begin
    if (reset)        flags <= 4'b0000;
    else if (ex_s_en) flags <= ex_flags;
  end

  // BL link-register write request and return address
  always_ff @(posedge clk) begin
    if (reset) begin
      link_we    <= 1'b0;
      link_value <= '0;
    end else begin
      link_we <= link_req;
      if (link_req) link_value <= id_next_pc - PC_W'(4);
    end
  end

  // Saturating count of taken branches
  always_ff @(posedge clk) begin
    if (reset)                               br_count <= '0;
    else if (branch_taken && (br_count != '1)) br_count <= br_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Self-checking bench for cond_branch_unit: condition sweep table plus
// hand sequences; registered outputs checked through an expectation queue.
module tb_cond_branch_unit;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid, id_b_instr, id_bl_instr, id_stall, ex_s_en;
  logic [3:0]        id_cond, ex_flags;
  logic [23:0]       id_imm24;
  logic [PC_W-1:0]   id_next_pc;
  logic [3:0]        flags;
  logic              cond_pass, branch_taken, link_we;
  logic [PC_W-1:0]   branch_target, link_value;
  logic [CNT_W-1:0]  br_count;

  cond_branch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_b_instr(id_b_instr),
    .id_bl_instr(id_bl_instr), .id_cond(id_cond), .id_imm24(id_imm24),
    .id_next_pc(id_next_pc), .id_stall(id_stall), .ex_s_en(ex_s_en),
    .ex_flags(ex_flags), .flags(flags), .cond_pass(cond_pass),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .link_we(link_we), .link_value(link_value), .br_count(br_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string            name;
    logic             lw;
    logic [PC_W-1:0]  lv;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       flg;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flg;
    logic       pass;
  } vec_t;
  vec_t vecs[256];

  // Reference condition table written from the ARM definitions
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z == 1'b1;
      4'h1: return z == 1'b0;
      4'h2: return cy == 1'b1;
      4'h3: return cy == 1'b0;
      4'h4: return n == 1'b1;
      4'h5: return n == 1'b0;
      4'h6: return v == 1'b1;
      4'h7: return v == 1'b0;
      4'h8: return (cy == 1'b1) && (z == 1'b0);
      4'h9: return !((cy == 1'b1) && (z == 1'b0));
      4'hA: return (n ^ v) == 1'b0;
      4'hB: return (n ^ v) == 1'b1;
      4'hC: return (z == 1'b0) && ((n ^ v) == 1'b0);
      4'hD: return !((z == 1'b0) && ((n ^ v) == 1'b0));
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input logic lw, input logic [PC_W-1:0] lv,
                          input logic [CNT_W-1:0] cnt, input logic [3:0] flg);
    exp_t e;
    e.name = nm; e.lw = lw; e.lv = lv; e.cnt = cnt; e.flg = flg;
    sbq.push_back(e);
  endtask

  // Advance one cycle and check every expectation queued for this edge
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.name, ".link_we"},    32'(link_we),    32'(e.lw));
      chk({e.name, ".link_value"}, link_value,      e.lv);
      chk({e.name, ".br_count"},   32'(br_count),   32'(e.cnt));
      chk({e.name, ".flags"},      32'(flags),      32'(e.flg));
    end
  endtask

  task automatic set_br(input logic v, input logic b, input logic bl, input logic [3:0] c,
                        input logic [23:0] imm, input logic [31:0] npc);
    id_valid = v; id_b_instr = b; id_bl_instr = bl; id_cond = c;
    id_imm24 = imm; id_next_pc = npc;
  endtask

  initial begin
    logic [CNT_W-1:0] ecnt;

    for (int i = 0; i < 256; i++) begin
      vecs[i].flg  = 4'(i >> 4);
      vecs[i].cond = 4'(i);
      vecs[i].pass = ref_cond(vecs[i].cond, vecs[i].flg);
    end

    reset = 1'b1; id_stall = 1'b0; ex_s_en = 1'b0; ex_flags = 4'b0000;
    set_br(1'b0, 1'b0, 1'b0, 4'hE, 24'h0, 32'h0);
    tick();
    push_exp("reset", 1'b0, 32'h0, 4'd0, 4'h0);
    tick();
    reset = 1'b0;

    // B AL forward
    set_br(1'b1, 1'b1, 1'b0, 4'hE, 24'h000004, 32'h100);
    #1;
    chk("b_al.taken", 32'(branch_taken), 32'd1);
    chk("b_al.target", branch_target, 32'h110);
    push_exp("b_al", 1'b0, 32'h0, 4'd1, 4'h0);
    tick();
    // Shadow: same valid B AL must not resolve
    #1;
    chk("shadow.taken", 32'(branch_taken), 32'd0);
    push_exp("shadow", 1'b0, 32'h0, 4'd1, 4'h0);
    tick();

    // BL AL backward
    set_br(1'b1, 1'b0, 1'b1, 4'hE, 24'hFFFFFE, 32'h208);
    #1;
    chk("bl.taken", 32'(branch_taken), 32'd1);
    chk("bl.target", branch_target, 32'h200);
    push_exp("bl", 1'b1, 32'h204, 4'd2, 4'h0);
    tick();
    set_br(1'b0, 1'b0, 1'b0, 4'hE, 24'h0, 32'h0);
    push_exp("bl_pulse_end", 1'b0, 32'h204, 4'd2, 4'h0);
    tick();

    // BEQ taken through the same-cycle flag bypass
    ex_s_en = 1'b1; ex_flags = 4'b0100;
    set_br(1'b1, 1'b1, 1'b0, 4'h0, 24'h0, 32'h300);
    #1;
    chk("beq_bypass.taken", 32'(branch_taken), 32'd1);
    push_exp("beq_bypass", 1'b0, 32'h204, 4'd3, 4'h4);
    tick();
    ex_s_en = 1'b0; ex_flags = 4'b0000;
    set_br(1'b0, 1'b0, 1'b0, 4'hE, 24'h0, 32'h0);
    push_exp("beq_shadow", 1'b0, 32'h204, 4'd3, 4'h4);
    tick();
    set_br(1'b1, 1'b1, 1'b0, 4'h1, 24'h0, 32'h310);
    #1;
    chk("bne.pass", 32'(cond_pass), 32'd0);
    chk("bne.taken", 32'(branch_taken), 32'd0);
    push_exp("bne", 1'b0, 32'h204, 4'd3, 4'h4);
    tick();

    // Stall holds the branch; release lets it resolve
    id_stall = 1'b1;
    set_br(1'b1, 1'b1, 1'b0, 4'hE, 24'h0, 32'h400);
    #1;
    chk("stall.taken", 32'(branch_taken), 32'd0);
    push_exp("stall", 1'b0, 32'h204, 4'd3, 4'h4);
    tick();
    id_stall = 1'b0;
    #1;
    chk("unstall.taken", 32'(branch_taken), 32'd1);
    push_exp("unstall", 1'b0, 32'h204, 4'd4, 4'h4);
    tick();
    // Stall during shadow does not extend it
    id_stall = 1'b1;
    set_br(1'b0, 1'b0, 1'b0, 4'hE, 24'h0, 32'h0);
    push_exp("stall_shadow", 1'b0, 32'h204, 4'd4, 4'h4);
    tick();
    id_stall = 1'b0;
    set_br(1'b1, 1'b1, 1'b0, 4'hE, 24'h0, 32'h420);
    #1;
    chk("after_stall_shadow.taken", 32'(branch_taken), 32'd1);
    push_exp("after_stall_shadow", 1'b0, 32'h204, 4'd5, 4'h4);
    tick();
    set_br(1'b0, 1'b0, 1'b0, 4'hE, 24'h0, 32'h0);
    push_exp("shadow2", 1'b0, 32'h204, 4'd5, 4'h4);
    tick();

    // Reserved condition never executes
    set_br(1'b1, 1'b1, 1'b0, 4'hF, 24'h0, 32'h440);
    #1;
    chk("condF.taken", 32'(branch_taken), 32'd0);
    push_exp("condF", 1'b0, 32'h204, 4'd5, 4'h4);
    tick();

    // Target wraps modulo 2^32
    set_br(1'b0, 1'b0, 1'b0, 4'hE, 24'h000001, 32'hFFFFFFFC);
    #1;
    chk("wrap.target", branch_target, 32'h0);
    chk("novalid.taken", 32'(branch_taken), 32'd0);

    // Condition sweep over registered flags
    for (int i = 0; i < 256; i++) begin
      if (vecs[i].cond == 4'h0) begin
        ex_s_en = 1'b1; ex_flags = vecs[i].flg;
        push_exp("flag_load", 1'b0, 32'h204, 4'd5, vecs[i].flg);
        tick();
        ex_s_en = 1'b0; ex_flags = ~vecs[i].flg;
      end
      id_cond = vecs[i].cond;
      #1;
      chk($sformatf("sweep.c%h.f%h", vecs[i].cond, vecs[i].flg), 32'(cond_pass), 32'(vecs[i].pass));
    end

    // Reset in shadow with a BL link write pending
    set_br(1'b1, 1'b0, 1'b1, 4'hE, 24'h0, 32'h508);
    #1;
    chk("bl2.taken", 32'(branch_taken), 32'd1);
    push_exp("bl2", 1'b1, 32'h504, 4'd6, 4'hF);
    tick();
    reset = 1'b1; ex_s_en = 1'b1; ex_flags = 4'b1010;
    push_exp("reset_shadow", 1'b0, 32'h0, 4'd0, 4'h0);
    tick();
    reset = 1'b0; ex_s_en = 1'b0;
    set_br(1'b1, 1'b1, 1'b0, 4'hE, 24'h0, 32'h600);
    #1;
    chk("post_reset.taken", 32'(branch_taken), 32'd1);
    push_exp("post_reset", 1'b0, 32'h0, 4'd1, 4'h0);
    tick();
    set_br(1'b0, 1'b0, 1'b0, 4'hE, 24'h0, 32'h0);
    push_exp("post_reset_shadow", 1'b0, 32'h0, 4'd1, 4'h0);
    tick();

    // Counter saturation
    ecnt = 4'd1;
    for (int k = 0; k < 17; k++) begin
      set_br(1'b1, 1'b1, 1'b0, 4'hE, 24'h0, 32'h700);
      if (ecnt != 4'hF) ecnt = ecnt + 4'd1;
      push_exp("sat", 1'b0, 32'h0, ecnt, 4'h0);
      tick();
      set_br(1'b0, 1'b0, 1'b0, 4'hE, 24'h0, 32'h0);
      tick();
    end
    chk("sat.final", 32'(br_count), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
- Decode-stage resolver for B/BL in the 5-stage ARM-subset pipeline; the back-channel to the IF/ID register.
- Holds the NZCV status flags, written from EX when the S bit is set.
- Evaluates each ID instruction's 4-bit condition field and computes the branch target.
- On a taken branch, redirects fetch and flushes IF/ID; for BL, issues a registered link-register write request.

Parameters:
- PC_W, 32, program-counter and target width
- CNT_W, 16, width of the saturating taken-branch counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  IF/ID holds a real instruction
- id_b_instr  input  1  ID instruction is B
- id_bl_instr  input  1  ID instruction is BL
- id_cond  input  4  instruction bits 31:28
- id_imm24  input  24  instruction bits 23:0
- id_next_pc  input  PC_W  ID instruction address + 8
- id_stall  input  1  hazard unit holding ID this cycle
- ex_s_en  input  1  EX instruction updates flags
- ex_flags  input  4  {N,Z,C,V} from ALU
- flags  output  4  registered {N,Z,C,V}
- cond_pass  output  1  ID condition true (combinational)
- branch_taken  output  1  fetch redirect and IF/ID flush (combinational)
- branch_target  output  PC_W  redirect address
- link_we  output  1  registered R14 write request
- link_value  output  PC_W  registered return address
- br_count  output  CNT_W  taken branches since reset, saturating

Behaviour:
- Reset, synchronous and active-high, dominating all other inputs:
  - flags=0, link_we=0, link_value=0, br_count=0, state=RUN.
- Flag register:
  - On a rising edge with ex_s_en=1: flags <= ex_flags; otherwise hold.
  - Flag updates are independent of id_stall.
- Effective flags for evaluation = ex_s_en ? ex_flags : flags (same-cycle bypass).
- cond_pass by id_cond on the effective flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F 0 (reserved, never executes)
- branch_taken = id_valid & !id_stall & (id_b_instr|id_bl_instr) & cond_pass & (state==RUN).
- branch_target = id_next_pc + {sign-extend(id_imm24), 2'b00}:
  - PC_W-bit modular add; wraps past 0xFFFFFFFF without a flag.
  - Output is driven every cycle and is meaningful only when branch_taken=1.
- State machine:
  - RUN: a taken branch moves to SHADOW at the edge.
  - SHADOW: lasts exactly one cycle, then returns to RUN.
    - branch_taken is forced 0 and link/count updates are suppressed.
    - The ID slot holds the flushed fetch, which must not resolve even if id_valid is glitched high.
  - id_stall in RUN: no transition, no outputs latched.
  - id_stall in SHADOW: SHADOW still ends after one cycle, because the bubble is already in IF/ID.
- Link write:
  - link_we <= branch_taken & id_bl_instr.
  - link_value <= id_next_pc - 4 (address + 4), latched only when link_we is set.
  - link_we is a one-cycle pulse.
  - BL with a failed condition gives no write.
- If both id_b_instr and id_bl_instr are high, treat as BL.
- br_count increments on each taken branch and saturates at all-ones.
- Latency:
  - cond_pass, branch_taken and branch_target are 0-cycle.
  - flags, link_we, link_value and br_count are 1-cycle.
- Reset asserted while in SHADOW returns to RUN on that edge; no pending link write survives.

Test Plan:
- Reset, then B with AL, imm24=0x000004, id_next_pc=0x100 -> same cycle branch_taken=1, target=0x110; next cycle br_count=1, link_we=0, state SHADOW.
- BL AL, imm24=0xFFFFFE (-2), id_next_pc=0x208 -> target=0x200; next cycle link_we=1, link_value=0x204; the cycle after, link_we=0.
- ex_s_en=1, ex_flags=0100 (Z) in the same cycle as BEQ in ID -> taken via bypass; next cycle flags=0100; BNE following (after SHADOW) -> not taken.
- Sweep all 16 conds × all 16 flag values with the flag register loaded -> cond_pass matches the table; cond F is never taken.
- Taken B, then id_valid=1 and id_b_instr=1 AL in the SHADOW cycle -> branch_taken=0, br_count unchanged.
- B AL with id_stall=1 -> branch_taken=0, no state change; releasing the stall -> taken. Reset asserted in SHADOW with BL pending -> next cycle link_we=0, flags=0, br_count=0.
